// File: rtl/vga_arb_pkg.sv
// vga_arb_pkg: shared widths, screen defaults and arbiter state encoding
package vga_arb_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COL_W = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam logic [COL_W-1:0] BLACK = 3'b000;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE, CLEAR} state_e;
endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// rr_pick: first set request at or above the pointer, wrapping around
module rr_pick #(
  parameter int N = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] win_o,
  output logic          valid_o
);
  // scan from the farthest offset down so the nearest request above the pointer wins
  always_comb begin
    win_o = '0;
    for (int i = N - 1; i >= 0; i--)
      win_o = req_i[(int'(ptr_i) + i) % N] ? PW'((int'(ptr_i) + i) % N) : win_o;
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin, burst-locked sharing of the VGA pixel-write port; CLEAR_ON_RESET_EN adds a post-reset screen clear
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_BURST = 256,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [X_W*NUM_REQ-1:0]   x_in,
  input  logic [Y_W*NUM_REQ-1:0]   y_in,
  input  logic [COL_W*NUM_REQ-1:0] colour_in,
  input  logic [NUM_REQ-1:0]       we_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [COL_W-1:0]         colour,
  output logic                     writeEn,
  output logic                     busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 2);
  localparam logic [NUM_REQ-1:0] ONE = 1;
  if (NUM_REQ < 2 || NUM_REQ > 8) $error("NUM_REQ must be 2..8");
  if (SCREEN_W > 2 ** X_W || SCREEN_H > 2 ** Y_W) $error("screen exceeds pixel coordinate range");
  state_e state_q;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [COL_W-1:0] col_q;
  logic we_q, win_v, leave;
`ifdef CLEAR_ON_RESET_EN
  logic [X_W-1:0] cx_q;
  logic [Y_W-1:0] cy_q;
  logic cx_end, cy_end;
  assign cx_end = cx_q == X_W'(SCREEN_W - 1);
  assign cy_end = cy_q == Y_W'(SCREEN_H - 1);
`endif
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .win_o  (win),
    .valid_o(win_v)
  );
  // the owner leaves when it drops its request or when its burst is used up while someone else waits
  assign leave = !req[owner_q] || (MAX_BURST != 0 && cnt_q == CW'(MAX_BURST - 1) && |(req & ~grant_q));
  assign cnt_d = (cnt_q == CW'(MAX_BURST)) ? cnt_q : cnt_q + 1'b1;
  assign ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // arbiter FSM with all adapter-facing outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef CLEAR_ON_RESET_EN
      state_q <= CLEAR;
      cx_q <= '0;
      cy_q <= '0;
`else
      state_q <= IDLE;
`endif
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      grant_q <= '0;
      x_q <= '0;
      y_q <= '0;
      col_q <= BLACK;
      we_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          we_q <= 1'b0;
          if (win_v) begin
            grant_q <= ONE << win;
            owner_q <= win;
            cnt_q <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          x_q <= x_in[X_W*owner_q +: X_W];
          y_q <= y_in[Y_W*owner_q +: Y_W];
          col_q <= colour_in[COL_W*owner_q +: COL_W];
          we_q <= !leave && we_in[owner_q];
          cnt_q <= cnt_d;
          if (leave) begin
            grant_q <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          we_q <= 1'b0;
          grant_q <= '0;
          ptr_q <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
`ifdef CLEAR_ON_RESET_EN
          x_q <= cx_q;
          y_q <= cy_q;
          col_q <= BLACK;
          we_q <= 1'b1;
          cx_q <= cx_end ? '0 : cx_q + 1'b1;
          cy_q <= cx_end ? cy_q + 1'b1 : cy_q;
          if (cx_end && cy_end) state_q <= IDLE;
`else
          we_q <= 1'b0;
          grant_q <= '0;
          state_q <= IDLE;
`endif
        end
      endcase
    end
  end
  assign grant = grant_q;
  assign x_out = x_q;
  assign y_out = y_q;
  assign colour = col_q;
  assign writeEn = we_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: directed scoreboard bench for the VGA write arbiter
module tb_vga_write_arbiter;
  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;
  logic clk = 0, reset = 0;
  logic [2:0] req = 0, we_in = 0;
  logic [23:0] x_in = 0;
  logic [20:0] y_in = 0;
  logic [8:0] colour_in = 0;
  logic [2:0] grant, grant0, colour, colour0;
  logic [7:0] x_out, x0;
  logic [6:0] y_out, y0;
  logic writeEn, we0, busy, busy0;
  int vectors = 0, miscompares = 0, gap = 0;
  int len[3];
  logic [7:0] px[3];
  logic [6:0] py[3];
  logic [2:0] pc[3];
  pix_t sb[$];
  logic [2:0] gq[$];
  logic [2:0] prev_g = 0;
  logic [2:0] g[1:14], g0[1:14];
  bit had_owner = 0, auto_on = 1, clearing = 0;

  vga_write_arbiter #(.MAX_BURST(8)) dut (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .we_in(we_in),
    .grant(grant), .x_out(x_out), .y_out(y_out), .colour(colour), .writeEn(writeEn), .busy(busy)
  );
  vga_write_arbiter #(.MAX_BURST(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .we_in(we_in),
    .grant(grant0), .x_out(x0), .y_out(y0), .colour(colour0), .writeEn(we0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    pix_t e, p;
    @(posedge clk);
    #1;
    if (!clearing && writeEn) begin
      check("sb_has_pixel", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pix_x", x_out, e.x);
        check("pix_y", y_out, e.y);
        check("pix_colour", colour, e.c);
      end
    end
    if (!clearing) check("we_needs_grant", writeEn && grant == 3'b000, 0);
    check("grant_onehot0", $onehot0(grant), 1);
    if (grant != 0 && prev_g == 0 && gq.size() > 0) begin
      check("grant_order", grant, gq.pop_front());
      if (had_owner) check("owner_gap", gap, 2);
    end
    if (grant != 0) had_owner = 1;
    gap = (grant == 0) ? gap + 1 : 0;
    prev_g = grant;
    if (auto_on)
      for (int r = 0; r < 3; r++) begin
        if (len[r] > 0 && grant[r]) begin
          req[r] = 1; we_in[r] = 1;
          x_in[8*r +: 8] = px[r]; y_in[7*r +: 7] = py[r]; colour_in[3*r +: 3] = pc[r];
          p.x = px[r]; p.y = py[r]; p.c = pc[r];
          sb.push_back(p);
          px[r]++; py[r]++; len[r]--;
        end else if (len[r] > 0) begin
          req[r] = 1; we_in[r] = 1;
          x_in[8*r +: 8] = 8'd99; y_in[7*r +: 7] = 7'd99; colour_in[3*r +: 3] = 3'd7;
        end else begin
          req[r] = 0; we_in[r] = 0;
          x_in[8*r +: 8] = 0; y_in[7*r +: 7] = 0; colour_in[3*r +: 3] = 0;
        end
      end
  endtask

  task automatic start(input int r, input int n, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    len[r] = n; px[r] = x; py[r] = y; pc[r] = c;
    req[r] = 1; we_in[r] = 1;
    x_in[8*r +: 8] = 8'd99; y_in[7*r +: 7] = 7'd99; colour_in[3*r +: 3] = 3'd7;
  endtask

  task automatic wait_grant(input int r, input string tag);
    int k = 0;
    while (grant[r] !== 1'b1 && k < 50) begin tick(); k++; end
    check(tag, k < 50, 1);
  endtask

  task automatic run_quiet(input string tag);
    int k = 0;
    while ((len[0] + len[1] + len[2] != 0 || busy || busy0 || writeEn) && k < 300) begin tick(); k++; end
    check(tag, k < 300, 1);
  endtask

  task automatic do_reset();
    reset = 0;
    for (int r = 0; r < 3; r++) len[r] = 0;
    req = 0; we_in = 0; x_in = 0; y_in = 0; colour_in = 0;
    sb.delete(); gq.delete(); had_owner = 0;
    tick();
    check("rst_grant", grant, 0);
    check("rst_grant_nb", grant0, 0);
    check("rst_we", writeEn, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_colour", colour, 0);
`ifdef CLEAR_ON_RESET_EN
    check("rst_busy", busy, 1);
`else
    check("rst_busy", busy, 0);
`endif
    reset = 1;
`ifdef CLEAR_ON_RESET_EN
    begin
      int k = 0, n = 0;
      logic [7:0] lx = 0;
      logic [6:0] ly = 0;
      clearing = 1;
      while (k < 20000) begin
        tick();
        k++;
        if (writeEn) begin
          n++; lx = x_out; ly = y_out;
          check("clear_colour", colour, 0);
        end
        if (!busy) break;
      end
      clearing = 0;
      check("clear_count", n, 19200);
      check("clear_last_x", lx, 159);
      check("clear_last_y", ly, 119);
    end
`endif
  endtask

  initial begin
    for (int r = 0; r < 3; r++) len[r] = 0;
    do_reset();

    // single requester
    start(0, 3, 8'd10, 7'd20, 3'b100);
    tick();
    check("single_grant", grant, 3'b001);
    check("single_busy", busy, 1);
    tick();
    check("single_we", writeEn, 1);
    check("single_x", x_out, 10);
    check("single_y", y_out, 20);
    check("single_colour", colour, 3'b100);
    begin
      int k = 0;
      while (len[0] != 0 && k < 20) begin tick(); k++; end
      check("single_stream_bound", k < 20, 1);
    end
    tick();
    tick();
    check("drop_grant", grant, 0);
    check("drop_we", writeEn, 0);
    check("drop_busy_hold", busy, 1);
    tick();
    check("drop_busy_low", busy, 0);
    check("single_drained", sb.size(), 0);

    // round-robin fairness with requester 0 coming back
    do_reset();
    gq.push_back(3'b001); gq.push_back(3'b010); gq.push_back(3'b100); gq.push_back(3'b001);
    start(0, 4, 8'd30, 7'd40, 3'd1);
    start(1, 4, 8'd50, 7'd60, 3'd2);
    start(2, 4, 8'd70, 7'd80, 3'd3);
    begin
      int k = 0;
      while (!(len[0] == 0 && grant[0] == 0) && k < 100) begin tick(); k++; end
      check("rr_first_burst_bound", k < 100, 1);
    end
    start(0, 4, 8'd90, 7'd100, 3'd5);
    run_quiet("rr_quiet");
    check("rr_all_grants_seen", gq.size(), 0);
    check("rr_drained", sb.size(), 0);

    // ungranted stream never reaches the adapter
    start(0, 5, 8'd1, 7'd2, 3'd6);
    wait_grant(0, "ug_owner_bound");
    start(1, 2, 8'd110, 7'd50, 3'd7);
    begin
      int k = 0;
      while (grant[1] == 0 && k < 50) begin
        tick();
        k++;
        check("ug_x_hidden", x_out == 8'd99, 0);
      end
      check("ug_grant1_bound", k < 50, 1);
    end
    run_quiet("ug_quiet");
    check("ug_drained", sb.size(), 0);

    // preemption after 8 cycles vs never (MAX_BURST=0)
    auto_on = 0;
    req = 3'b001; we_in = 0; x_in = 0; y_in = 0; colour_in = 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      g[c] = grant; g0[c] = grant0;
      if (c == 2) req[1] = 1;
    end
    check("pre_first", g[1], 3'b001);
    check("pre_last_burst", g[8], 3'b001);
    check("pre_release", g[9], 0);
    check("pre_idle", g[10], 0);
    check("pre_next_owner", g[11], 3'b010);
    check("nopre_hold", g0[11], 3'b001);
    begin
      int n = 0;
      for (int c = 1; c <= 11; c++) n += (g[c] == 3'b001) ? 1 : 0;
      check("pre_burst_len", n, 8);
    end
    req = 3'b010;
    tick();
    check("nopre_release", grant0, 0);
    tick();
    tick();
    check("nopre_next_owner", grant0, 3'b010);
    check("pre_owner_kept", grant, 3'b010);
    req = 0;
    run_quiet("pre_quiet");
    auto_on = 1;

    // reset mid-burst, then pointer back at 0
    start(0, 10, 8'd5, 7'd5, 3'd1);
    wait_grant(0, "mid_owner_bound");
    tick();
    tick();
    do_reset();
    gq.push_back(3'b010); gq.push_back(3'b100);
    start(1, 2, 8'd20, 7'd30, 3'd2);
    start(2, 2, 8'd40, 7'd50, 3'd3);
    run_quiet("mid_quiet");
    check("mid_grants_seen", gq.size(), 0);
    check("mid_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
